// File: rtl/riscv_decode_pkg.sv
// ============================================================================
// riscv_decode_pkg : instruction indices, opcode/funct constants and decoder
// Rev 1.0
// ============================================================================
`default_nettype none

package riscv_decode_pkg;

    localparam int INST_W = 58;

    // Bit positions in the one-hot instruction vector, shared with execute.
    // Indices 30 and above are reserved for execute-side extensions.
    localparam int ENUM_INST_ANDI  = 0;
    localparam int ENUM_INST_ADDI  = 1;
    localparam int ENUM_INST_SLTI  = 2;
    localparam int ENUM_INST_SLTIU = 3;
    localparam int ENUM_INST_ORI   = 4;
    localparam int ENUM_INST_XORI  = 5;
    localparam int ENUM_INST_SLLI  = 6;
    localparam int ENUM_INST_SRLI  = 7;
    localparam int ENUM_INST_SRAI  = 8;
    localparam int ENUM_INST_LUI   = 9;
    localparam int ENUM_INST_AUIPC = 10;
    localparam int ENUM_INST_ADD   = 11;
    localparam int ENUM_INST_SUB   = 12;
    localparam int ENUM_INST_SLT   = 13;
    localparam int ENUM_INST_SLTU  = 14;
    localparam int ENUM_INST_XOR   = 15;
    localparam int ENUM_INST_OR    = 16;
    localparam int ENUM_INST_AND   = 17;
    localparam int ENUM_INST_SLL   = 18;
    localparam int ENUM_INST_SRL   = 19;
    localparam int ENUM_INST_SRA   = 20;
    localparam int ENUM_INST_JAL   = 21;
    localparam int ENUM_INST_JALR  = 22;
    localparam int ENUM_INST_BEQ   = 23;
    localparam int ENUM_INST_BNE   = 24;
    localparam int ENUM_INST_BLT   = 25;
    localparam int ENUM_INST_BGE   = 26;
    localparam int ENUM_INST_BLTU  = 27;
    localparam int ENUM_INST_BGEU  = 28;
    localparam int ENUM_INST_MUL   = 29;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_BASE   = 7'h00;
    localparam logic [6:0] F7_ALT    = 7'h20;
    localparam logic [6:0] F7_MULDIV = 7'h01;

    typedef logic [INST_W-1:0] inst_vec_t;

    // Returns all-zero for any encoding execute does not implement.
    function automatic inst_vec_t decode_instr(input logic [31:0] instr,
                                               input logic        support_mul);
        inst_vec_t  v;
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        v   = '0;
        opc = instr[6:0];
        f3  = instr[14:12];
        f7  = instr[31:25];
        case (opc)
            OPC_OP_IMM: begin
                case (f3)
                    3'b000: v[ENUM_INST_ADDI]  = 1'b1;
                    3'b010: v[ENUM_INST_SLTI]  = 1'b1;
                    3'b011: v[ENUM_INST_SLTIU] = 1'b1;
                    3'b100: v[ENUM_INST_XORI]  = 1'b1;
                    3'b110: v[ENUM_INST_ORI]   = 1'b1;
                    3'b111: v[ENUM_INST_ANDI]  = 1'b1;
                    3'b001: v[ENUM_INST_SLLI]  = (f7 == F7_BASE);
                    3'b101: begin
                        v[ENUM_INST_SRLI] = (f7 == F7_BASE);
                        v[ENUM_INST_SRAI] = (f7 == F7_ALT);
                    end
                    default: v = '0;
                endcase
            end
            OPC_OP: begin
                if (f7 == F7_BASE) begin
                    case (f3)
                        3'b000:  v[ENUM_INST_ADD]  = 1'b1;
                        3'b001:  v[ENUM_INST_SLL]  = 1'b1;
                        3'b010:  v[ENUM_INST_SLT]  = 1'b1;
                        3'b011:  v[ENUM_INST_SLTU] = 1'b1;
                        3'b100:  v[ENUM_INST_XOR]  = 1'b1;
                        3'b101:  v[ENUM_INST_SRL]  = 1'b1;
                        3'b110:  v[ENUM_INST_OR]   = 1'b1;
                        default: v[ENUM_INST_AND]  = 1'b1;
                    endcase
                end else if (f7 == F7_ALT) begin
                    v[ENUM_INST_SUB] = (f3 == 3'b000);
                    v[ENUM_INST_SRA] = (f3 == 3'b101);
                end else if (f7 == F7_MULDIV) begin
                    v[ENUM_INST_MUL] = support_mul && (f3 == 3'b000);
                end
            end
            OPC_LUI:   v[ENUM_INST_LUI]   = 1'b1;
            OPC_AUIPC: v[ENUM_INST_AUIPC] = 1'b1;
            OPC_JAL:   v[ENUM_INST_JAL]   = 1'b1;
            OPC_JALR:  v[ENUM_INST_JALR]  = (f3 == 3'b000);
            OPC_BRANCH: begin
                case (f3)
                    3'b000:  v[ENUM_INST_BEQ]  = 1'b1;
                    3'b001:  v[ENUM_INST_BNE]  = 1'b1;
                    3'b100:  v[ENUM_INST_BLT]  = 1'b1;
                    3'b101:  v[ENUM_INST_BGE]  = 1'b1;
                    3'b110:  v[ENUM_INST_BLTU] = 1'b1;
                    3'b111:  v[ENUM_INST_BGEU] = 1'b1;
                    default: v = '0;
                endcase
            end
            default: v = '0;
        endcase
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/riscv_decode_regfile.sv
// ============================================================================
// riscv_regfile : 32x32 integer register file, 2 async reads, 1 sync write
// Rev 1.0
// ============================================================================
`default_nettype none

module riscv_regfile (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [4:0]  ra_idx_i,
    input  logic [4:0]  rb_idx_i,
    output logic [31:0] ra_data_o,
    output logic [31:0] rb_data_o,
    input  logic        wr_en_i,
    input  logic [4:0]  wr_idx_i,
    input  logic [31:0] wr_data_i
);

    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];

    always_comb begin
        regs_d = regs_q;
        if (wr_en_i) begin
            regs_d[wr_idx_i] = wr_data_i;
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign ra_data_o = (ra_idx_i == 5'd0) ? 32'd0 : regs_q[ra_idx_i];
    assign rb_data_o = (rb_idx_i == 5'd0) ? 32'd0 : regs_q[rb_idx_i];

endmodule

`default_nettype wire

// File: rtl/riscv_decode.sv
// ============================================================================
// riscv_decode : decode / operand-fetch stage feeding execute, with bypassing
// Rev 1.0
// ============================================================================
`default_nettype none

module riscv_decode
    import riscv_decode_pkg::*;
#(
    parameter bit SUPPORT_MUL      = 1'b1,
    parameter bit FLUSH_ON_UNKNOWN = 1'b0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              fetch_valid_i,
    input  logic [31:0]       fetch_instr_i,
    input  logic [31:0]       fetch_pc_i,
    output logic              fetch_accept_o,
    input  logic              branch_request_i,
    input  logic              exec_stall_i,
    input  logic [4:0]        writeback_idx_i,
    input  logic [31:0]       writeback_value_i,
    input  logic              writeback_squash_i,
    output logic              opcode_valid_o,
    output logic [INST_W-1:0] opcode_instr_o,
    output logic [31:0]       opcode_opcode_o,
    output logic [31:0]       opcode_pc_o,
    output logic [4:0]        opcode_rd_idx_o,
    output logic [4:0]        opcode_ra_idx_o,
    output logic [4:0]        opcode_rb_idx_o,
    output logic [31:0]       opcode_ra_operand_o,
    output logic [31:0]       opcode_rb_operand_o,
    output logic              unknown_o
);

    logic              valid_q,      valid_d;
    logic [INST_W-1:0] instr_q,      instr_d;
    logic [31:0]       opcode_q,     opcode_d;
    logic [31:0]       pc_q,         pc_d;
    logic [4:0]        rd_idx_q,     rd_idx_d;
    logic [4:0]        ra_idx_q,     ra_idx_d;
    logic [4:0]        rb_idx_q,     rb_idx_d;
    logic [31:0]       ra_operand_q, ra_operand_d;
    logic [31:0]       rb_operand_q, rb_operand_d;
    logic              unknown_q,    unknown_d;

    logic              w_accept;
    logic              w_wb_en;
    logic [4:0]        w_fetch_ra;
    logic [4:0]        w_fetch_rb;
    logic [31:0]       w_rf_ra;
    logic [31:0]       w_rf_rb;
    logic [31:0]       w_cap_ra;
    logic [31:0]       w_cap_rb;
    logic              w_out_hit_ra;
    logic              w_out_hit_rb;
    inst_vec_t         w_fetch_inst;
    logic              w_fetch_unknown;
    logic              w_fetch_live;

    assign w_accept   = !exec_stall_i;
    assign w_wb_en    = (writeback_idx_i != 5'd0) && !writeback_squash_i;
    assign w_fetch_ra = fetch_instr_i[19:15];
    assign w_fetch_rb = fetch_instr_i[24:20];

    riscv_regfile u_regfile (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .ra_idx_i  (w_fetch_ra),
        .rb_idx_i  (w_fetch_rb),
        .ra_data_o (w_rf_ra),
        .rb_data_o (w_rf_rb),
        .wr_en_i   (w_wb_en),
        .wr_idx_i  (writeback_idx_i),
        .wr_data_i (writeback_value_i)
    );

    assign w_fetch_inst    = decode_instr(fetch_instr_i, SUPPORT_MUL);
    assign w_fetch_unknown = (w_fetch_inst == '0);
    assign w_fetch_live    = fetch_valid_i && !branch_request_i;

    // The register file write lands on the same edge, so the read port is stale.
    assign w_cap_ra = (w_wb_en && (writeback_idx_i == w_fetch_ra)) ? writeback_value_i : w_rf_ra;
    assign w_cap_rb = (w_wb_en && (writeback_idx_i == w_fetch_rb)) ? writeback_value_i : w_rf_rb;

    assign w_out_hit_ra = (ra_idx_q != 5'd0) && (ra_idx_q == writeback_idx_i) && !writeback_squash_i;
    assign w_out_hit_rb = (rb_idx_q != 5'd0) && (rb_idx_q == writeback_idx_i) && !writeback_squash_i;

    always_comb begin
        valid_d      = valid_q;
        instr_d      = instr_q;
        opcode_d     = opcode_q;
        pc_d         = pc_q;
        rd_idx_d     = rd_idx_q;
        ra_idx_d     = ra_idx_q;
        rb_idx_d     = rb_idx_q;
        ra_operand_d = ra_operand_q;
        rb_operand_d = rb_operand_q;
        unknown_d    = 1'b0;
        if (w_accept) begin
            valid_d      = w_fetch_live && !(FLUSH_ON_UNKNOWN && w_fetch_unknown);
            instr_d      = w_fetch_inst;
            opcode_d     = fetch_instr_i;
            pc_d         = fetch_pc_i;
            rd_idx_d     = fetch_instr_i[11:7];
            ra_idx_d     = w_fetch_ra;
            rb_idx_d     = w_fetch_rb;
            ra_operand_d = w_cap_ra;
            rb_operand_d = w_cap_rb;
            unknown_d    = w_fetch_live && w_fetch_unknown;
        end else begin
            if (branch_request_i) begin
                valid_d = 1'b0;
            end
            // Held operands absorb a writeback so they stay correct once it ends.
            if (w_out_hit_ra) begin
                ra_operand_d = writeback_value_i;
            end
            if (w_out_hit_rb) begin
                rb_operand_d = writeback_value_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q      <= 1'b0;
            instr_q      <= '0;
            opcode_q     <= '0;
            pc_q         <= '0;
            rd_idx_q     <= '0;
            ra_idx_q     <= '0;
            rb_idx_q     <= '0;
            ra_operand_q <= '0;
            rb_operand_q <= '0;
            unknown_q    <= 1'b0;
        end else begin
            valid_q      <= valid_d;
            instr_q      <= instr_d;
            opcode_q     <= opcode_d;
            pc_q         <= pc_d;
            rd_idx_q     <= rd_idx_d;
            ra_idx_q     <= ra_idx_d;
            rb_idx_q     <= rb_idx_d;
            ra_operand_q <= ra_operand_d;
            rb_operand_q <= rb_operand_d;
            unknown_q    <= unknown_d;
        end
    end

    assign fetch_accept_o      = w_accept;
    assign opcode_valid_o      = valid_q;
    assign opcode_instr_o      = instr_q;
    assign opcode_opcode_o     = opcode_q;
    assign opcode_pc_o         = pc_q;
    assign opcode_rd_idx_o     = rd_idx_q;
    assign opcode_ra_idx_o     = ra_idx_q;
    assign opcode_rb_idx_o     = rb_idx_q;
    assign opcode_ra_operand_o = w_out_hit_ra ? writeback_value_i : ra_operand_q;
    assign opcode_rb_operand_o = w_out_hit_rb ? writeback_value_i : rb_operand_q;
    assign unknown_o           = unknown_q;

endmodule

`default_nettype wire
